// File: rtl/instr_encoder_if.sv
// Descriptor-in / machine-word-out stream bundle for the MIPS instruction encoder.
// The master side produces descriptors and consumes words. The slave side is the encoder.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_code;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [31:0] out_addr;
   logic [15:0] err_count;

   modport master (
      output in_valid, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
      input  in_ready, out_valid, out_word, out_addr, err_count
   );

   modport slave (
      input  in_valid, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
      output in_ready, out_valid, out_word, out_addr, err_count
   );
endinterface

// File: rtl/instr_encoder.sv
// Streaming MIPS assembler: internal instruction code plus fields in, 32-bit word and byte address out.
// Illegal codes are consumed and counted. Legal words queue in a small FIFO with contiguous addresses.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int          DEPTH     = 4
) (
   input  logic           clk,
   input  logic           reset,
   instr_encoder_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [5:0] {
      C_ILL = 6'd0, C_ADD, C_ADDU, C_SUB, C_SUBU, C_AND, C_OR, C_XOR, C_NOR, C_SLT, C_SLTU,
      C_SLLV, C_SRLV, C_SRAV, C_SLL, C_SRL, C_SRA, C_MULT, C_MULTU, C_DIV, C_DIVU,
      C_JR, C_JALR, C_MFHI, C_MFLO, C_MTHI, C_MTLO,
      C_ADDI, C_ADDIU, C_SLTI, C_SLTIU, C_ANDI, C_ORI, C_XORI, C_LB, C_LH, C_LW, C_LBU, C_LHU,
      C_SB, C_SH, C_SW, C_BEQ, C_BNE, C_LUI, C_BLEZ, C_BGTZ, C_BLTZ, C_BGEZ, C_J, C_JAL
   } code_t;

   // Field layout classes. Any field not named by the class is forced to zero.
   typedef enum logic [3:0] {
      K_ILL, K_RSTD, K_RTDS, K_RST, K_RS, K_RSD, K_RD, K_ISTI, K_ITI, K_ISI, K_J
   } kind_t;

   typedef struct packed {
      kind_t      kind;
      logic [5:0] op;
      logic [5:0] aux;
   } dec_t;

   dec_t        dec;
   logic        legal;
   logic [31:0] enc_word;

   always_comb begin
      dec = '{K_ILL, 6'h00, 6'h00};
      case (bus.in_code)
         C_ADD:   dec = '{K_RSTD, 6'h00, 6'h20};
         C_ADDU:  dec = '{K_RSTD, 6'h00, 6'h21};
         C_SUB:   dec = '{K_RSTD, 6'h00, 6'h22};
         C_SUBU:  dec = '{K_RSTD, 6'h00, 6'h23};
         C_AND:   dec = '{K_RSTD, 6'h00, 6'h24};
         C_OR:    dec = '{K_RSTD, 6'h00, 6'h25};
         C_XOR:   dec = '{K_RSTD, 6'h00, 6'h26};
         C_NOR:   dec = '{K_RSTD, 6'h00, 6'h27};
         C_SLT:   dec = '{K_RSTD, 6'h00, 6'h2A};
         C_SLTU:  dec = '{K_RSTD, 6'h00, 6'h2B};
         C_SLLV:  dec = '{K_RSTD, 6'h00, 6'h04};
         C_SRLV:  dec = '{K_RSTD, 6'h00, 6'h06};
         C_SRAV:  dec = '{K_RSTD, 6'h00, 6'h07};
         C_SLL:   dec = '{K_RTDS, 6'h00, 6'h00};
         C_SRL:   dec = '{K_RTDS, 6'h00, 6'h02};
         C_SRA:   dec = '{K_RTDS, 6'h00, 6'h03};
         C_MULT:  dec = '{K_RST,  6'h00, 6'h18};
         C_MULTU: dec = '{K_RST,  6'h00, 6'h19};
         C_DIV:   dec = '{K_RST,  6'h00, 6'h1A};
         C_DIVU:  dec = '{K_RST,  6'h00, 6'h1B};
         C_JR:    dec = '{K_RS,   6'h00, 6'h08};
         C_JALR:  dec = '{K_RSD,  6'h00, 6'h09};
         C_MFHI:  dec = '{K_RD,   6'h00, 6'h10};
         C_MFLO:  dec = '{K_RD,   6'h00, 6'h12};
         C_MTHI:  dec = '{K_RS,   6'h00, 6'h11};
         C_MTLO:  dec = '{K_RS,   6'h00, 6'h13};
         C_ADDI:  dec = '{K_ISTI, 6'h08, 6'h00};
         C_ADDIU: dec = '{K_ISTI, 6'h09, 6'h00};
         C_SLTI:  dec = '{K_ISTI, 6'h0A, 6'h00};
         C_SLTIU: dec = '{K_ISTI, 6'h0B, 6'h00};
         C_ANDI:  dec = '{K_ISTI, 6'h0C, 6'h00};
         C_ORI:   dec = '{K_ISTI, 6'h0D, 6'h00};
         C_XORI:  dec = '{K_ISTI, 6'h0E, 6'h00};
         C_LB:    dec = '{K_ISTI, 6'h20, 6'h00};
         C_LH:    dec = '{K_ISTI, 6'h21, 6'h00};
         C_LW:    dec = '{K_ISTI, 6'h23, 6'h00};
         C_LBU:   dec = '{K_ISTI, 6'h24, 6'h00};
         C_LHU:   dec = '{K_ISTI, 6'h25, 6'h00};
         C_SB:    dec = '{K_ISTI, 6'h28, 6'h00};
         C_SH:    dec = '{K_ISTI, 6'h29, 6'h00};
         C_SW:    dec = '{K_ISTI, 6'h2B, 6'h00};
         C_BEQ:   dec = '{K_ISTI, 6'h04, 6'h00};
         C_BNE:   dec = '{K_ISTI, 6'h05, 6'h00};
         C_LUI:   dec = '{K_ITI,  6'h0F, 6'h00};
         C_BLEZ:  dec = '{K_ISI,  6'h06, 6'h00};
         C_BGTZ:  dec = '{K_ISI,  6'h07, 6'h00};
         C_BLTZ:  dec = '{K_ISI,  6'h01, 6'h00};
         C_BGEZ:  dec = '{K_ISI,  6'h01, 6'h01};
         C_J:     dec = '{K_J,    6'h02, 6'h00};
         C_JAL:   dec = '{K_J,    6'h03, 6'h00};
         default: dec = '{K_ILL,  6'h00, 6'h00};
      endcase
   end

   // aux carries funct for R-type and the fixed rt selector for the rs/imm branch forms.
   always_comb begin
      legal    = 1'b1;
      enc_word = 32'h0;
      case (dec.kind)
         K_RSTD:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, dec.aux};
         K_RTDS:  enc_word = {6'h00, 5'h00, bus.in_rt, bus.in_rd, bus.in_shamt, dec.aux};
         K_RST:   enc_word = {6'h00, bus.in_rs, bus.in_rt, 10'h000, dec.aux};
         K_RS:    enc_word = {6'h00, bus.in_rs, 15'h0000, dec.aux};
         K_RSD:   enc_word = {6'h00, bus.in_rs, 5'h00, bus.in_rd, 5'h00, dec.aux};
         K_RD:    enc_word = {6'h00, 10'h000, bus.in_rd, 5'h00, dec.aux};
         K_ISTI:  enc_word = {dec.op, bus.in_rs, bus.in_rt, bus.in_imm};
         K_ITI:   enc_word = {dec.op, 5'h00, bus.in_rt, bus.in_imm};
         K_ISI:   enc_word = {dec.op, bus.in_rs, dec.aux[4:0], bus.in_imm};
         K_J:     enc_word = {dec.op, bus.in_target};
         default: legal = 1'b0;
      endcase
   end

   logic [31:0]      mem_word [DEPTH];
   logic [31:0]      mem_addr [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [31:0]      next_addr;
   logic [31:0]      last_word;
   logic [31:0]      last_addr;
   logic [15:0]      err_cnt;
   logic             accept;
   logic             push;
   logic             pop;

   assign bus.in_ready  = (count < CNT_W'(DEPTH));
   assign bus.out_valid = (count != '0);
   assign accept        = bus.in_valid && bus.in_ready;
   assign push          = accept && legal;
   assign pop           = bus.out_valid && bus.out_ready;
   assign bus.out_word  = bus.out_valid ? mem_word[rd_ptr] : last_word;
   assign bus.out_addr  = bus.out_valid ? mem_addr[rd_ptr] : last_addr;
   assign bus.err_count = err_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         next_addr <= BASE_ADDR;
         last_word <= 32'h0;
         last_addr <= BASE_ADDR;
         err_cnt   <= 16'h0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + 1'b1;
            next_addr <= next_addr + 32'd4;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            last_word <= mem_word[rd_ptr];
            last_addr <= mem_addr[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (accept && !legal && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
   end

   // Storage needs no reset: entries are only visible while count says they are valid.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_word[wr_ptr] <= enc_word;
         mem_addr[wr_ptr] <= next_addr;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed machine words and addresses.
module tb_instr_encoder;
   localparam int DEPTH = 4;

   localparam logic [5:0] C_ADDU = 6'd2,  C_SLL = 6'd14, C_JR = 6'd21, C_MFHI = 6'd23;
   localparam logic [5:0] C_ORI  = 6'd32, C_LW  = 6'd36, C_LUI = 6'd44, C_BLTZ = 6'd47;
   localparam logic [5:0] C_BGEZ = 6'd48, C_J   = 6'd49, C_JAL = 6'd50, C_BAD  = 6'd63;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_encoder_if bus();

   instr_encoder #(.BASE_ADDR(32'h0000_3000), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [5:0] code, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt);
      bus.in_valid  = 1'b1;
      bus.in_code   = code;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_shamt  = sh;
      bus.in_imm    = imm;
      bus.in_target = tgt;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      exp_addr = 32'h0000_3000;
   endtask

   // Called at a negedge with out_ready=1; the word must be at the head half a cycle after accept.
   task automatic send_chk(input string tag, input logic [5:0] code, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [25:0] tgt,
                           input logic [31:0] exp_word);
      drive(code, rs, rt, rd, sh, imm, tgt);
      check({tag, "/rdy"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, "/vld"}, 32'(bus.out_valid), 32'd1);
      check({tag, "/word"}, bus.out_word, exp_word);
      check({tag, "/addr"}, bus.out_addr, exp_addr);
      exp_addr = exp_addr + 32'd4;
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      bus.in_valid  = 1'b0;
      exp_addr      = 32'h0000_3000;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst/vld",  32'(bus.out_valid), 32'd0);
      check("rst/word", bus.out_word, 32'h0);
      check("rst/addr", bus.out_addr, 32'h0000_3000);
      check("rst/err",  32'(bus.err_count), 32'd0);
      check("rst/rdy",  32'(bus.in_ready), 32'd1);
      reset = 1'b0;

      // Single-word encodes; each pop overlaps the next push.
      bus.out_ready = 1'b1;
      @(negedge clk);
      drive(C_ADDU, 5'd1, 5'd2, 5'd3, 5'd7, 16'hFFFF, 26'h3FFFFFF);
      check("addu/pre_vld", 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b0;
      send_chk("addu",  C_ADDU, 5'd1,  5'd2, 5'd3, 5'd7, 16'hFFFF, 26'h3FFFFFF, 32'h0022_1821);
      send_chk("jal",   C_JAL,  5'd9,  5'd9, 5'd9, 5'd9, 16'h1234, 26'h0000C00, 32'h0C00_0C00);
      send_chk("sll",   C_SLL,  5'h1F, 5'd1, 5'd2, 5'd4, 16'hFFFF, 26'h0,       32'h0001_1100);
      send_chk("ori",   C_ORI,  5'd0,  5'd1, 5'd9, 5'd9, 16'h1234, 26'h3FFFFFF, 32'h3401_1234);
      send_chk("bgez",  C_BGEZ, 5'd5,  5'd7, 5'd3, 5'd3, 16'hFFFE, 26'h0,       32'h04A1_FFFE);
      send_chk("jr",    C_JR,   5'd31, 5'd7, 5'd9, 5'd1, 16'h5555, 26'h0,       32'h03E0_0008);
      send_chk("lui",   C_LUI,  5'd3,  5'd4, 5'd6, 5'd2, 16'hABCD, 26'h0,       32'h3C04_ABCD);
      send_chk("lw",    C_LW,   5'd29, 5'd8, 5'd1, 5'd1, 16'h0010, 26'h0,       32'h8FA8_0010);
      send_chk("mfhi",  C_MFHI, 5'd1,  5'd2, 5'd5, 5'd3, 16'h00FF, 26'h0,       32'h0000_2810);
      send_chk("bltz",  C_BLTZ, 5'd2,  5'd5, 5'd0, 5'd0, 16'h0008, 26'h0,       32'h0440_0008);
      send_chk("j",     C_J,    5'd1,  5'd1, 5'd1, 5'd1, 16'h0,    26'h3FFFFFF, 32'h0BFF_FFFF);

      // Illegal code between two legal ones.
      do_reset();
      bus.out_ready = 1'b1;
      send_chk("ill/a", C_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3401_1234);
      drive(C_BAD, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
      check("ill/rdy", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("ill/vld",  32'(bus.out_valid), 32'd0);
      check("ill/err",  32'(bus.err_count), 32'd1);
      check("ill/hold", bus.out_word, 32'h3401_1234);
      send_chk("ill/b", C_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1821);

      // Backpressure: DEPTH+1 offered, DEPTH accepted, drained in order.
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         drive(C_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'h0);
         check($sformatf("bp/rdy%0d", i), 32'(bus.in_ready), (i < DEPTH) ? 32'd1 : 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("bp/vld%0d", i),  32'(bus.out_valid), 32'd1);
         check($sformatf("bp/word%0d", i), bus.out_word, 32'h3401_0000 + 32'(i));
         check($sformatf("bp/addr%0d", i), bus.out_addr, 32'h0000_3000 + 32'(4 * i));
         @(posedge clk);
         @(negedge clk);
      end
      check("bp/empty",     32'(bus.out_valid), 32'd0);
      check("bp/hold_word", bus.out_word, 32'h3401_0003);
      check("bp/hold_addr", bus.out_addr, 32'h0000_300C);

      // Reset with three words queued and an accept in flight.
      do_reset();
      bus.out_ready = 1'b1;
      drive(C_BAD, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("mid/err_pre", 32'(bus.err_count), 32'd1);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(C_ORI, 5'd0, 5'd2, 5'd0, 5'd0, 16'(16'h100 + i), 26'h0);
         @(posedge clk);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("mid/vld_pre", 32'(bus.out_valid), 32'd1);
      reset = 1'b1;
      drive(C_ORI, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0BAD, 26'h0);
      @(posedge clk);
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      check("mid/vld",  32'(bus.out_valid), 32'd0);
      check("mid/err",  32'(bus.err_count), 32'd0);
      check("mid/word", bus.out_word, 32'h0);
      check("mid/addr", bus.out_addr, 32'h0000_3000);
      bus.out_ready = 1'b1;
      exp_addr      = 32'h0000_3000;
      send_chk("mid/next", C_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1821);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
